ysyx_23060025_rd_arbiter: RTL and testbench

Two-master read-channel arbiter that shares the single DRAM read port between the instruction cache (M0) and the LSU (M1). It sits between the icache/LSU AXI-lite-style read masters and the memory-side slave. The arbiter grants one whole transaction at a time: one address phase plus the full burst ending in `rlast`. It registers the address phase, passes the data phase through, and checks burst length.

---
 rtl/ysyx_23060025_rd_arbiter_pkg.sv | 19 +
 rtl/ysyx_23060025_rr_pick.sv | 32 +++
 rtl/ysyx_23060025_rd_arbiter.sv | 149 ++++++++++++++
 tb/tb_ysyx_23060025_rd_arbiter.sv | 389 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_23060025_rd_arbiter_pkg.sv
// Shared encodings for the two-master DRAM read arbiter.
// State, grant and AXI response codes used across the arbiter files.
package ysyx_23060025_rd_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    ADDR = 2'b01,
    DATA = 2'b10
  } arb_state_e;

  typedef enum logic {
    GNT_M0 = 1'b0,
    GNT_M1 = 1'b1
  } gnt_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/ysyx_23060025_rr_pick.sv
// Combinational 2-way picker: round-robin by default, fixed M0
// priority when YSYX_23060025_ARB_FIXED_PRIO_EN is defined.
module ysyx_23060025_rr_pick
  import ysyx_23060025_rd_arbiter_pkg::*;
(
  input  logic [1:0] req_i,
  input  gnt_e       last_i,
  output gnt_e       gnt_o,
  output logic       valid_o
);

`ifdef YSYX_23060025_ARB_FIXED_PRIO_EN
  gnt_e tie_gnt;
  logic unused_last;
  assign tie_gnt     = GNT_M0;
  assign unused_last = last_i;
`else
  gnt_e tie_gnt;
  assign tie_gnt = (last_i == GNT_M0) ? GNT_M1 : GNT_M0;
`endif

  always_comb begin
    valid_o = |req_i;
    gnt_o   = GNT_M0;
    unique case (req_i)
      2'b11:   gnt_o = tie_gnt;
      2'b10:   gnt_o = GNT_M1;
      default: gnt_o = GNT_M0;
    endcase
  end

endmodule

// File: rtl/ysyx_23060025_rd_arbiter.sv
// Two-master read arbiter: registered AR phase, pass-through R phase,
// sticky burst-length check. Option: YSYX_23060025_ARB_FIXED_PRIO_EN.
module ysyx_23060025_rd_arbiter
  import ysyx_23060025_rd_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] m0_araddr,
  input  logic                  m0_arvalid,
  output logic                  m0_arready,
  input  logic [7:0]            m0_arlen,
  input  logic [2:0]            m0_arsize,
  output logic                  m0_rvalid,
  output logic [DATA_WIDTH-1:0] m0_rdata,
  output logic [1:0]            m0_rresp,
  output logic                  m0_rlast,
  input  logic                  m0_rready,
  input  logic [ADDR_WIDTH-1:0] m1_araddr,
  input  logic                  m1_arvalid,
  output logic                  m1_arready,
  input  logic [7:0]            m1_arlen,
  input  logic [2:0]            m1_arsize,
  output logic                  m1_rvalid,
  output logic [DATA_WIDTH-1:0] m1_rdata,
  output logic [1:0]            m1_rresp,
  output logic                  m1_rlast,
  input  logic                  m1_rready,
  output logic [ADDR_WIDTH-1:0] s_araddr,
  output logic                  s_arvalid,
  input  logic                  s_arready,
  output logic [7:0]            s_arlen,
  output logic [2:0]            s_arsize,
  input  logic                  s_rvalid,
  input  logic [DATA_WIDTH-1:0] s_rdata,
  input  logic [1:0]            s_rresp,
  input  logic                  s_rlast,
  output logic                  s_rready,
  output logic                  len_err
);

  arb_state_e state_q, state_d;
  gnt_e gnt_q, gnt_d;
  gnt_e last_q, last_d;
  gnt_e pick_gnt;
  logic pick_vld;
  logic [8:0] cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [7:0] len_q, len_d;
  logic [2:0] size_q, size_d;
  logic err_q, err_d;
  logic in_data, sel1, beat;

  ysyx_23060025_rr_pick u_pick (
    .req_i   ({m1_arvalid, m0_arvalid}),
    .last_i  (last_q),
    .gnt_o   (pick_gnt),
    .valid_o (pick_vld)
  );

  assign in_data = (state_q == DATA);
  assign sel1    = (gnt_q == GNT_M1);

  // R channel is only routed in DATA; stray slave beats elsewhere are dropped.
  assign s_rready  = in_data & (sel1 ? m1_rready : m0_rready);
  assign beat      = s_rvalid & s_rready;

  assign m0_rvalid = in_data & ~sel1 & s_rvalid;
  assign m0_rdata  = (in_data & ~sel1) ? s_rdata : '0;
  assign m0_rresp  = (in_data & ~sel1) ? s_rresp : RESP_OKAY;
  assign m0_rlast  = in_data & ~sel1 & s_rlast;

  assign m1_rvalid = in_data & sel1 & s_rvalid;
  assign m1_rdata  = (in_data & sel1) ? s_rdata : '0;
  assign m1_rresp  = (in_data & sel1) ? s_rresp : RESP_OKAY;
  assign m1_rlast  = in_data & sel1 & s_rlast;

  assign s_arvalid = (state_q == ADDR);
  assign s_araddr  = addr_q;
  assign s_arlen   = len_q;
  assign s_arsize  = size_q;
  assign len_err   = err_q;

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    last_d     = last_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    len_d      = len_q;
    size_d     = size_q;
    err_d      = err_q;
    m0_arready = 1'b0;
    m1_arready = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pick_vld) begin
          m0_arready = (pick_gnt == GNT_M0);
          m1_arready = (pick_gnt == GNT_M1);
          gnt_d      = pick_gnt;
          addr_d     = (pick_gnt == GNT_M1) ? m1_araddr : m0_araddr;
          len_d      = (pick_gnt == GNT_M1) ? m1_arlen : m0_arlen;
          size_d     = (pick_gnt == GNT_M1) ? m1_arsize : m0_arsize;
          cnt_d      = '0;
          state_d    = ADDR;
        end
      end
      ADDR: begin
        if (s_arready) state_d = DATA;
      end
      DATA: begin
        if (beat) begin
          cnt_d = cnt_q + 9'd1;
          if (s_rlast) begin
            state_d = IDLE;
            last_d  = gnt_q;
            if ((cnt_q + 9'd1) != ({1'b0, len_q} + 9'd1)) err_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      gnt_q   <= GNT_M0;
      last_q  <= GNT_M1;
      cnt_q   <= '0;
      addr_q  <= '0;
      len_q   <= '0;
      size_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      size_q  <= size_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_ysyx_23060025_rd_arbiter.sv
// Self-checking bench for ysyx_23060025_rd_arbiter with a
// transaction-level reference model of grant order and length errors.
module tb_ysyx_23060025_rd_arbiter;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  logic [31:0] m0_araddr, m1_araddr, s_araddr;
  logic m0_arvalid, m1_arvalid, m0_arready, m1_arready;
  logic [7:0] m0_arlen, m1_arlen, s_arlen;
  logic [2:0] m0_arsize, m1_arsize, s_arsize;
  logic m0_rvalid, m1_rvalid, m0_rlast, m1_rlast;
  logic [31:0] m0_rdata, m1_rdata, s_rdata;
  logic [1:0] m0_rresp, m1_rresp, s_rresp;
  logic m0_rready, m1_rready;
  logic s_arvalid, s_arready, s_rvalid, s_rlast, s_rready, len_err;

  ysyx_23060025_rd_arbiter dut (
    .clock(clock), .reset(reset),
    .m0_araddr(m0_araddr), .m0_arvalid(m0_arvalid), .m0_arready(m0_arready),
    .m0_arlen(m0_arlen), .m0_arsize(m0_arsize),
    .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_rresp(m0_rresp),
    .m0_rlast(m0_rlast), .m0_rready(m0_rready),
    .m1_araddr(m1_araddr), .m1_arvalid(m1_arvalid), .m1_arready(m1_arready),
    .m1_arlen(m1_arlen), .m1_arsize(m1_arsize),
    .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_rresp(m1_rresp),
    .m1_rlast(m1_rlast), .m1_rready(m1_rready),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_arlen(s_arlen), .s_arsize(s_arsize),
    .s_rvalid(s_rvalid), .s_rdata(s_rdata), .s_rresp(s_rresp),
    .s_rlast(s_rlast), .s_rready(s_rready), .len_err(len_err)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int last_m = 1;
  bit exp_err = 1'b0;

  // Grant rule: a tie goes to the master not granted last time.
  function automatic int model_pick(input bit r0, input bit r1);
    if (r0 && r1) begin
`ifdef YSYX_23060025_ARB_FIXED_PRIO_EN
      return 0;
`else
      return (last_m == 0) ? 1 : 0;
`endif
    end
    return r1 ? 1 : 0;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    m0_arvalid = 0; m1_arvalid = 0;
    m0_araddr = 0; m1_araddr = 0;
    m0_arlen = 0; m1_arlen = 0;
    m0_arsize = 3'd2; m1_arsize = 3'd2;
    m0_rready = 1; m1_rready = 1;
    s_arready = 0; s_rvalid = 0; s_rdata = 0;
    s_rresp = 0; s_rlast = 0;
    repeat (2) tick();
    reset = 1'b1;
    tick();
    last_m = 1;
    exp_err = 1'b0;
  endtask

  // Raise requests, wait for the arready pulse, drop the winner's arvalid.
  task automatic issue(input bit r0, input bit r1,
                       input logic [31:0] a0, input logic [31:0] a1,
                       input logic [7:0] l0, input logic [7:0] l1,
                       output int who, output int pulses);
    who = -1;
    pulses = 0;
    if (r0) begin m0_arvalid = 1; m0_araddr = a0; m0_arlen = l0; end
    if (r1) begin m1_arvalid = 1; m1_araddr = a1; m1_arlen = l1; end
    for (int k = 0; k < 20; k++) begin
      @(negedge clock);
      pulses = int'(m0_arready) + int'(m1_arready);
      if (pulses > 0) begin
        who = m1_arready ? 1 : 0;
        tick();
        if (who == 0) m0_arvalid = 0;
        else m1_arvalid = 0;
        break;
      end
      tick();
    end
  endtask

  // Slave side of one burst; observes both master R ports.
  task automatic slave_burst(input int exp_m, input int nbeats,
                             input logic [31:0] base, input int ar_dly,
                             input int stall_at, input int stall_n,
                             output int got, output int bad,
                             output logic [31:0] addr_seen,
                             output logic [7:0] len_seen);
    int k;
    logic gv, ov;
    logic [31:0] od;
    got = 0;
    bad = 0;
    addr_seen = 'x;
    len_seen = 'x;
    k = 0;
    while (!s_arvalid && k < 20) begin tick(); k++; end
    if (!s_arvalid) begin bad++; return; end
    addr_seen = s_araddr;
    len_seen = s_arlen;
    repeat (ar_dly) begin
      tick();
      if (!s_arvalid || s_araddr !== addr_seen) bad++;
    end
    s_arready = 1;
    tick();
    s_arready = 0;
    if (s_arvalid) bad++;
    for (int i = 0; i < nbeats; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        s_rvalid = 0;
        tick();
      end
      s_rvalid = 1;
      s_rdata = base + i;
      s_rresp = ($urandom_range(0, 1) == 1) ? 2'b10 : 2'b00;
      s_rlast = (i == nbeats - 1);
      if (i == stall_at) begin
        m0_rready = 0; m1_rready = 0;
        repeat (stall_n) begin
          @(negedge clock);
          gv = (exp_m == 1) ? m1_rvalid : m0_rvalid;
          if (s_rready !== 1'b0 || gv !== 1'b1) bad++;
          tick();
        end
        m0_rready = 1; m1_rready = 1;
      end
      @(negedge clock);
      gv = (exp_m == 1) ? m1_rvalid : m0_rvalid;
      ov = (exp_m == 1) ? m0_rvalid : m1_rvalid;
      od = (exp_m == 1) ? m0_rdata : m1_rdata;
      if (s_rready !== 1'b1) bad++;
      if (ov !== 1'b0 || od !== 32'h0) bad++;
      if (m0_arready !== 1'b0 || m1_arready !== 1'b0) bad++;
      if (exp_m == 1) begin
        if (gv && m1_rdata === base + i && m1_rlast === s_rlast &&
            m1_rresp === s_rresp) got++;
      end else begin
        if (gv && m0_rdata === base + i && m0_rlast === s_rlast &&
            m0_rresp === s_rresp) got++;
      end
      tick();
    end
    s_rvalid = 0;
    s_rlast = 0;
  endtask

  task automatic test_reset();
    apply_reset();
    @(negedge clock);
    if (s_arvalid !== 1'b0) begin n_bad++; $display("FAIL reset_s_arvalid: got %b want 0", s_arvalid); end
    n_cmp++;
    if (s_araddr !== 32'h0) begin n_bad++; $display("FAIL reset_s_araddr: got %h want 0", s_araddr); end
    n_cmp++;
    if ({m0_rvalid, m1_rvalid, s_rready} !== 3'b000) begin
      n_bad++; $display("FAIL reset_r: got %b want 000", {m0_rvalid, m1_rvalid, s_rready});
    end
    n_cmp++;
    if (len_err !== 1'b0) begin n_bad++; $display("FAIL reset_len_err: got %b want 0", len_err); end
    n_cmp++;
    tick();
  endtask

  task automatic test_single_m0();
    int who, p, got, bad;
    logic [31:0] a;
    logic [7:0] l;
    issue(1, 0, 32'h8000_0010, 32'h0, 8'd0, 8'd0, who, p);
    if (who !== model_pick(1, 0) || p !== 1) begin
      n_bad++; $display("FAIL single_grant: got who=%0d pulses=%0d want 0/1", who, p);
    end
    n_cmp++;
    slave_burst(0, 1, 32'hDEAD_BEEF, 2, -1, 0, got, bad, a, l);
    last_m = 0;
    if (a !== 32'h8000_0010 || l !== 8'd0) begin
      n_bad++; $display("FAIL single_ar: got %h/%0d want 80000010/0", a, l);
    end
    n_cmp++;
    if (got !== 1 || bad !== 0) begin
      n_bad++; $display("FAIL single_data: got beats=%0d errs=%0d want 1/0", got, bad);
    end
    n_cmp++;
    if (len_err !== 1'b0) begin n_bad++; $display("FAIL single_len_err: got %b want 0", len_err); end
    n_cmp++;
  endtask

  task automatic test_tie_order();
    int who, p, got, bad, exp_w;
    logic [31:0] a;
    logic [7:0] l;
    for (int t = 0; t < 3; t++) begin
      exp_w = model_pick(1, 1);
      issue(1, 1, 32'h1000 + t * 16, 32'h2000 + t * 16, 8'd1, 8'd1, who, p);
      if (who !== exp_w || p !== 1) begin
        n_bad++; $display("FAIL tie_grant%0d: got who=%0d pulses=%0d want %0d/1", t, who, p, exp_w);
      end
      n_cmp++;
      slave_burst(exp_w, 2, 32'h5500 + t * 8, 1, -1, 0, got, bad, a, l);
      last_m = exp_w;
      if (got !== 2 || bad !== 0 ||
          a !== ((exp_w == 1) ? 32'h2000 + t * 16 : 32'h1000 + t * 16)) begin
        n_bad++; $display("FAIL tie_burst%0d: got beats=%0d errs=%0d addr=%h", t, got, bad, a);
      end
      n_cmp++;
    end
    m0_arvalid = 0;
    m1_arvalid = 0;
    tick();
  endtask

  task automatic test_backpressure();
    int who, p, got, bad;
    logic [31:0] a;
    logic [7:0] l;
    issue(0, 1, 32'h0, 32'h3000_0000, 8'd0, 8'd3, who, p);
    if (who !== model_pick(0, 1)) begin
      n_bad++; $display("FAIL bp_grant: got %0d want 1", who);
    end
    n_cmp++;
    m0_arvalid = 1; m0_araddr = 32'h4000_0000; m0_arlen = 8'd0;
    slave_burst(1, 4, 32'hA000_0000, 1, 1, 3, got, bad, a, l);
    last_m = 1;
    if (got !== 4 || bad !== 0 || l !== 8'd3) begin
      n_bad++; $display("FAIL bp_burst: got beats=%0d errs=%0d len=%0d want 4/0/3", got, bad, l);
    end
    n_cmp++;
    issue(1, 0, 32'h4000_0000, 32'h0, 8'd0, 8'd0, who, p);
    if (who !== model_pick(1, 0) || p !== 1) begin
      n_bad++; $display("FAIL bp_next_grant: got who=%0d pulses=%0d want 0/1", who, p);
    end
    n_cmp++;
    slave_burst(0, 1, 32'h77, 0, -1, 0, got, bad, a, l);
    last_m = 0;
    if (got !== 1 || bad !== 0 || a !== 32'h4000_0000) begin
      n_bad++; $display("FAIL bp_next_burst: got beats=%0d errs=%0d addr=%h", got, bad, a);
    end
    n_cmp++;
  endtask

  task automatic test_len_err();
    int who, p, got, bad;
    logic [31:0] a;
    logic [7:0] l;
    issue(1, 0, 32'h5000, 32'h0, 8'd3, 8'd0, who, p);
    slave_burst(0, 2, 32'h900, 0, -1, 0, got, bad, a, l);
    last_m = 0;
    exp_err = exp_err | (2 != 3 + 1);
    if (got !== 2 || bad !== 0 || who !== 0) begin
      n_bad++; $display("FAIL short_burst: got beats=%0d errs=%0d who=%0d", got, bad, who);
    end
    n_cmp++;
    if (len_err !== exp_err) begin n_bad++; $display("FAIL len_err_set: got %b want %b", len_err, exp_err); end
    n_cmp++;
    issue(0, 1, 32'h0, 32'h6000, 8'd0, 8'd0, who, p);
    if (who !== model_pick(0, 1)) begin n_bad++; $display("FAIL len_err_idle: got who=%0d want 1", who); end
    n_cmp++;
    slave_burst(1, 1, 32'h901, 0, -1, 0, got, bad, a, l);
    last_m = 1;
    if (len_err !== exp_err) begin n_bad++; $display("FAIL len_err_sticky: got %b want %b", len_err, exp_err); end
    n_cmp++;
  endtask

  task automatic test_reset_mid_burst();
    int who, p, got, bad, k;
    logic [31:0] a;
    logic [7:0] l;
    issue(1, 0, 32'h7000, 32'h0, 8'd3, 8'd0, who, p);
    k = 0;
    while (!s_arvalid && k < 10) begin tick(); k++; end
    s_arready = 1;
    tick();
    s_arready = 0;
    s_rvalid = 1; s_rdata = 32'hBAD0_0001; s_rlast = 0;
    @(negedge clock);
    if (m0_rvalid !== 1'b1) begin n_bad++; $display("FAIL rst_pre: got m0_rvalid=%b want 1", m0_rvalid); end
    n_cmp++;
    #1 reset = 1'b0;
    #1;
    if ({m0_rvalid, m1_rvalid, s_rready, s_arvalid, m0_arready, m1_arready, len_err} !== 7'b0 ||
        m0_rdata !== 32'h0 || s_araddr !== 32'h0) begin
      n_bad++; $display("FAIL rst_async: got %b data=%h addr=%h want all 0",
        {m0_rvalid, m1_rvalid, s_rready, s_arvalid, m0_arready, m1_arready, len_err}, m0_rdata, s_araddr);
    end
    n_cmp++;
    last_m = 1;
    exp_err = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    @(negedge clock);
    if ({m0_rvalid, m1_rvalid, s_rready} !== 3'b000) begin
      n_bad++; $display("FAIL rst_stale_idle: got %b want 000", {m0_rvalid, m1_rvalid, s_rready});
    end
    n_cmp++;
    tick();
    issue(0, 1, 32'h0, 32'h8800, 8'd0, 8'd0, who, p);
    if (who !== model_pick(0, 1)) begin n_bad++; $display("FAIL rst_regrant: got %0d want 1", who); end
    n_cmp++;
    @(negedge clock);
    if ({m0_rvalid, m1_rvalid, s_rready} !== 3'b000) begin
      n_bad++; $display("FAIL rst_stale_addr: got %b want 000", {m0_rvalid, m1_rvalid, s_rready});
    end
    n_cmp++;
    tick();
    s_rvalid = 0;
    slave_burst(1, 1, 32'hC0, 0, -1, 0, got, bad, a, l);
    last_m = 1;
    if (got !== 1 || bad !== 0 || a !== 32'h8800) begin
      n_bad++; $display("FAIL rst_m1_burst: got beats=%0d errs=%0d addr=%h", got, bad, a);
    end
    n_cmp++;
  endtask

  task automatic test_random();
    int who, p, got, bad, exp_w, nb;
    bit r0, r1;
    bit pend0, pend1;
    logic [31:0] a0, a1, a;
    logic [7:0] l0, l1, le, l;
    pend0 = 0; pend1 = 0;
    for (int t = 0; t < 24; t++) begin
      r0 = pend0 | ($urandom_range(0, 1) == 1);
      r1 = pend1 | ($urandom_range(0, 1) == 1);
      if (!r0 && !r1) r0 = 1;
      if (!pend0) begin a0 = $urandom & 32'hFFFF_FFFC; l0 = 8'($urandom_range(0, 3)); end
      if (!pend1) begin a1 = $urandom & 32'hFFFF_FFFC; l1 = 8'($urandom_range(0, 3)); end
      exp_w = model_pick(r0, r1);
      issue(r0, r1, a0, a1, l0, l1, who, p);
      if (who !== exp_w || p !== 1) begin
        n_bad++; $display("FAIL rnd_grant%0d: got who=%0d pulses=%0d want %0d/1", t, who, p, exp_w);
      end
      n_cmp++;
      le = (exp_w == 1) ? l1 : l0;
      nb = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 4) : int'(le) + 1;
      exp_err = exp_err | (nb != int'(le) + 1);
      slave_burst(exp_w, nb, $urandom, $urandom_range(0, 2),
                  ($urandom_range(0, 2) == 0) ? $urandom_range(0, nb - 1) : -1,
                  $urandom_range(1, 3), got, bad, a, l);
      last_m = exp_w;
      if (got !== nb || bad !== 0 || a !== ((exp_w == 1) ? a1 : a0) || l !== le) begin
        n_bad++; $display("FAIL rnd_burst%0d: got beats=%0d errs=%0d addr=%h len=%0d want %0d/0/%h/%0d",
          t, got, bad, a, l, nb, (exp_w == 1) ? a1 : a0, le);
      end
      n_cmp++;
      if (len_err !== exp_err) begin
        n_bad++; $display("FAIL rnd_len_err%0d: got %b want %b", t, len_err, exp_err);
      end
      n_cmp++;
      pend0 = r0 && (exp_w != 0);
      pend1 = r1 && (exp_w != 1);
    end
    m0_arvalid = 0;
    m1_arvalid = 0;
    tick();
  endtask

  initial begin
    test_reset();
    test_single_m0();
    test_tie_order();
    test_backpressure();
    test_len_err();
    test_reset_mid_burst();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
